// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating multiplexer.
// The packet-lock FSM state type is only used when ARB_MUX_PKT_LOCK_EN is defined.
package arb_mux_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Wrapping increment of a channel index: n-1 goes back to 0
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// slave is the mux view, master is the producer/consumer (environment) view.
interface rr_arb_mux_if #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS-1:0]   in_valid;
  logic [DATA_WIDTH-1:0] in_data [N_INPUTS];
  logic [N_INPUTS-1:0]   in_last;
  logic [N_INPUTS-1:0]   in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_last;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns the first requesting index
// found when searching ptr, ptr+1, ... with wrap at N-1 -> 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid
);

  logic [31:0]      w_cand;
  logic [SEL_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest request to ptr wins last
  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_cand      = '0;
    w_idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = (32'(i_ptr) + 32'(k)) % 32'(N);
      w_idx  = SEL_W'(w_cand);
      if (i_req[w_idx]) begin
        o_gnt_idx   = w_idx;
        o_gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with one registered output stage.
// Optional packet lock (define ARB_MUX_PKT_LOCK_EN): once a channel starts a
// multi-beat packet it keeps the grant until its in_last beat is accepted.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         clrn,
  rr_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [SEL_W-1:0]      r_rr_ptr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0]      r_out_sel;
  logic                  r_out_last;

  logic [N_INPUTS-1:0]   w_req;
  logic [SEL_W-1:0]      w_pick_ptr;
  logic [SEL_W-1:0]      w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_load;
  logic                  w_xfer;
  logic [SEL_W-1:0]      w_next_ptr;
  logic [N_INPUTS-1:0]   w_in_ready;

`ifdef ARB_MUX_PKT_LOCK_EN
  arb_state_t            r_state;
  logic [SEL_W-1:0]      r_lock_ch;

  // While a packet is open only its owner may request; others wait
  always_comb begin
    w_req      = bus.in_valid;
    w_pick_ptr = r_rr_ptr;
    if (r_state == ARB_LOCKED) begin
      w_req      = bus.in_valid & (N_INPUTS'(1) << r_lock_ch);
      w_pick_ptr = r_lock_ch;
    end
  end
`else
  assign w_req      = bus.in_valid;
  assign w_pick_ptr = r_rr_ptr;
`endif

  rr_pick #(
    .N     (N_INPUTS),
    .SEL_W (SEL_W)
  ) u_pick (
    .i_req       (w_req),
    .i_ptr       (w_pick_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_load     = !r_out_valid || bus.out_ready;
  assign w_xfer     = w_load && w_gnt_valid;
  assign w_next_ptr = SEL_W'(rr_next(32'(w_gnt_idx), N_INPUTS));

  // Accept strobe goes only to the granted channel, and never while stalled or in reset
  always_comb begin
    w_in_ready = '0;
    if (clrn && w_xfer) begin
      w_in_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_last  = r_out_last;

  // Output stage: load a granted beat, drain when empty-handed, hold under backpressure
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in_data[w_gnt_idx];
        r_out_sel   <= w_gnt_idx;
        r_out_last  <= bus.in_last[w_gnt_idx];
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  // Packet-lock FSM: the pointer only moves past a channel once its packet closes
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= ARB_IDLE;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_xfer) begin
            if (bus.in_last[w_gnt_idx]) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_state   <= ARB_LOCKED;
              r_lock_ch <= w_gnt_idx;
            end
          end
        end
        ARB_LOCKED: begin
          if (w_xfer && bus.in_last[w_gnt_idx]) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
`else
  // The winner of each accepted beat drops to lowest priority for the next one
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed table-driven bench for rr_arb_mux (4 channels, 32-bit data).
// The packet-lock sequence is compiled in only when ARB_MUX_PKT_LOCK_EN is defined.
module tb_rr_arb_mux;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  logic clk;
  logic clrn;
  int   nTests;
  int   nFail;

  rr_arb_mux_if #(.N_INPUTS(4), .DATA_WIDTH(32)) bus ();

  rr_arb_mux #(.N_INPUTS(4), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dat(input int v, input int c);
    return 32'hA000_0000 + 32'(v) * 32'h100 + 32'(c);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] last, input logic ordy, input int vidx);
    bus.in_valid  = v;
    bus.in_last   = last;
    bus.out_ready = ordy;
    for (int c = 0; c < 4; c++) bus.in_data[c] = dat(vidx, c);
  endtask

  // One vector: drive, check combinational in_ready, clock, check registered outputs
  task automatic runVec(input vec_t x, input int vidx, input string tag);
    applyStimulus(x.valid, x.last, x.ordy, vidx);
    #1;
    checkOutput($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(x.exp_rdy));
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(x.exp_ov));
    checkOutput($sformatf("%s out_sel", tag), 32'(bus.out_sel), 32'(x.exp_sel));
    checkOutput($sformatf("%s out_data", tag), bus.out_data, x.exp_data);
    checkOutput($sformatf("%s out_last", tag), 32'(bus.out_last), 32'(x.exp_last));
  endtask

  task automatic doReset();
    bus.in_valid = 4'b0000;
    clrn = 1'b0;
    #2;
    @(negedge clk);
    clrn = 1'b1;
    #1;
  endtask

  vec_t vecs[22];
`ifdef ARB_MUX_PKT_LOCK_EN
  vec_t lockVecs[8];
`endif

  initial begin
    nTests = 0;
    nFail  = 0;

    vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(0, 0), 1'b1};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, dat(1, 1), 1'b1};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, dat(2, 2), 1'b1};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, dat(3, 3), 1'b1};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(4, 0), 1'b1};
    vecs[5]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, dat(4, 0), 1'b1};
    vecs[6]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, dat(6, 2), 1'b1};
    vecs[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, dat(6, 2), 1'b1};
    vecs[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, dat(6, 2), 1'b1};
    vecs[9]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, dat(6, 2), 1'b1};
    vecs[10] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, dat(10, 3), 1'b1};
    vecs[11] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, dat(10, 3), 1'b1};
    vecs[12] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, dat(10, 3), 1'b1};
    vecs[13] = '{4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, dat(13, 0), 1'b1};
    vecs[14] = '{4'b0011, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, dat(13, 0), 1'b1};
    vecs[15] = '{4'b0011, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, dat(15, 1), 1'b1};
    vecs[16] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, dat(16, 3), 1'b1};
    vecs[17] = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(17, 0), 1'b1};
    vecs[18] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, dat(18, 3), 1'b1};
    vecs[19] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, dat(18, 3), 1'b1};
    vecs[20] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, dat(20, 1), 1'b0};
    vecs[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, dat(20, 1), 1'b0};

    // Reset state, with requests pending so in_ready gating is exercised
    clrn = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1'b1, 99);
    #3;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("reset out_data", bus.out_data, 32'd0);
    checkOutput("reset out_last", 32'(bus.out_last), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 4'b0000;
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle%0d out_valid", i), 32'(bus.out_valid), 32'd0);
      checkOutput($sformatf("idle%0d in_ready", i), 32'(bus.in_ready), 32'd0);
    end

    // Round-robin order, single-channel grant, backpressure and wrap
    for (int k = 0; k < 22; k++) begin
      runVec(vecs[k], k, $sformatf("vec%0d", k));
    end

    // Async reset mid-stream: pointer must restart at channel 0
    doReset();
    runVec('{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(200, 0), 1'b1}, 200, "rst pre0");
    runVec('{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, dat(201, 1), 1'b1}, 201, "rst pre1");
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("midrst out_data", bus.out_data, 32'd0);
    checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    checkOutput("postrst in_ready", 32'(bus.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("postrst out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("postrst out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("postrst out_data", bus.out_data, dat(201, 0));

`ifdef ARB_MUX_PKT_LOCK_EN
    // ch1 holds the grant for a 3-beat packet, including a gap, while ch0/ch3 wait
    lockVecs[0] = '{4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(100, 0), 1'b1};
    lockVecs[1] = '{4'b1011, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, dat(101, 1), 1'b0};
    lockVecs[2] = '{4'b1001, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd1, dat(101, 1), 1'b0};
    lockVecs[3] = '{4'b1011, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, dat(103, 1), 1'b0};
    lockVecs[4] = '{4'b1011, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, dat(104, 1), 1'b1};
    lockVecs[5] = '{4'b1001, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, dat(105, 3), 1'b1};
    lockVecs[6] = '{4'b1001, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, dat(106, 0), 1'b1};
    lockVecs[7] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, dat(106, 0), 1'b1};
    doReset();
    for (int k = 0; k < 8; k++) begin
      runVec(lockVecs[k], 100 + k, $sformatf("lock%0d", k));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
